ov7670_dvp_emulator: RTL and testbench
======================================

// Module: ov7670_dvp_emulator
// PURPOSE
// - Synthesizable OV7670 DVP source: emits VSYNC/HREF/D[7:0] byte stream in OV7670 VGA YUV422 timing.
// - Drives the cam_top capture path (and downstream BRAM/HDMI) without a physical camera, for bring-up and regression.
// - Output bits launch on the rising clk_24m edge; the top forwards inverted clk_24m as cam PCLK (outside this block).
// PARAMETERS
// - H_ACTIVE      640  active pixels per line (2 bytes each, HREF high for 2*H_ACTIVE clks)
// - H_BLANK       144  blank pixel times per line (HREF low for 2*H_BLANK clks)
// - V_SYNC        3    lines with VSYNC high
// - V_BACK        17   lines after VSYNC before first active line
// - V_ACTIVE      480  active lines
// - V_FRONT       10   lines after last active line
// PORTS
// - clk_24m       in   1  byte clock
// - rst_24m_n     in   1  asynchronous reset, active low
// - enable        in   1  run request; level-sensitive
// - pattern_sel   in   2  0 colour bars, 1 horizontal ramp, 2 solid frame-count, 3 checker 8x8
// - cam_VSYNC     out  1  frame sync, active high
// - cam_HREF      out  1  line valid, active high
// - cam_D         out  8  pixel byte
// - frame_done    out  1  one-clk pulse on last clk of V_FRONT
// - busy          out  1  high while a frame is in progress
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, state IDLE, h_cnt=v_cnt=0, frame_cnt=0.
// - Line = 2*(H_ACTIVE+H_BLANK) clks; h_cnt 0..LINE-1 wraps, v_cnt increments on wrap.
// - FSM: IDLE -> VSYNC (enable=1 sampled in IDLE) -> VBACK -> ACTIVE -> VFRONT -> VSYNC if enable else IDLE.
// - Each non-IDLE state lasts its parameter in whole lines; transitions at h_cnt wrap only.
// - cam_VSYNC=1 for every clk of VSYNC state; 0 elsewhere.
// - cam_HREF=1 in ACTIVE for h_cnt < 2*H_ACTIVE; cam_D=0x00 whenever HREF=0.
// - Byte order per pixel pair: U, Y0, V, Y1 (h_cnt[1:0]=0..3); H_ACTIVE must be even.
// - Registered outputs: HREF and D change on the same edge; first active byte one clk after h_cnt=0 decode.
// - pattern_sel and frame_cnt snapshot at VSYNC entry; held constant for the whole frame.
// - Patterns (x=pixel index, y=active line index):
//   0: 8 bars of H_ACTIVE/8 px; Y = 0xEB,0xD2,0xAA,0x91,0x6A,0x51,0x29,0x10; U=V=0x80
//   1: Y = x[7:0] (wraps every 256 px); U=V=0x80
//   2: Y = frame_cnt[7:0]; U=V=0x80
//   3: Y = (x[3]^y[3]) ? 0xFF : 0x00; U=V=0x80
// - frame_cnt: 8-bit, increments at frame_done, wraps 0xFF->0x00.
// - busy=1 from VSYNC entry through frame_done clk inclusive; 0 in IDLE.
// - enable dropped mid-frame: current frame completes unchanged; IDLE afterwards.
// - enable held high: back-to-back frames, no IDLE gap (VFRONT last clk -> VSYNC).
// - Reset mid-frame: outputs 0 immediately (async); restart only via IDLE.
// CONFIGURATION
// - DVP_EMU_LINE_TAG_EN defined: in every active line, Y0 of pixel 0 = {7'b0, y[8]}, Y1 of pixel 1 = y[7:0];
//   U/V and all other bytes unchanged. Receiver can check line ordering.
// - Undefined: pattern bytes unmodified; no tag logic synthesized.
// TESTING (sim params H_ACTIVE=8 H_BLANK=4 V_SYNC=1 V_BACK=1 V_ACTIVE=4 V_FRONT=1)
// - Reset, enable=0 for 200 clks -> VSYNC=HREF=busy=0, D=0x00 throughout.
// - enable=1, pattern 1 -> VSYNC high 24 clks; per active line HREF high 16 clks, D = 80,00,80,01,...,80,07; 4 lines.
// - enable held, 3 frames, pattern 2 -> Y bytes 0x00, 0x01, 0x02 per frame; frame_done every 7*24=168 clks.
// - pattern_sel toggled 0->3 during ACTIVE -> current frame stays bars; next frame checker.
// - enable dropped in VBACK -> frame completes, frame_done pulse, then busy=0 and no VSYNC.
// - rst_24m_n low mid-line -> all outputs 0 same clk; after release + enable, frame restarts from VSYNC.
// - With DVP_EMU_LINE_TAG_EN: line 2 bytes 1 and 3 = 0x00, 0x02.

Source files
------------

// File: rtl/ov7670_dvp_emulator.sv
// ov7670_dvp_emulator: synthesizable OV7670-style DVP byte source (VGA YUV422 timing).
// Produces VSYNC/HREF/D[7:0] so the camera capture path can be exercised without a sensor.
// Ports:
//   clk_24m      byte clock; all outputs launch on its rising edge
//   rst_24m_n    async active-low reset (asserted async, released through a 2-flop sync)
//   enable       level-sensitive run request
//   pattern_sel  0 colour bars, 1 horizontal ramp, 2 solid frame count, 3 checker 8x8
//   cam_VSYNC    frame sync, high for the whole VSYNC period
//   cam_HREF     line valid, high for the 2*H_ACTIVE active bytes of each active line
//   cam_D        pixel byte (U, Y0, V, Y1 order), 0x00 while HREF is low
//   frame_done   one-clk pulse on the last clk of the front porch
//   busy         high while a frame is in progress
// Optional feature: define DVP_EMU_LINE_TAG_EN to stamp the active line index into
// Y0 of pixel 0 ({7'b0, y[8]}) and Y1 of pixel 1 (y[7:0]) of every active line.
`timescale 1ns/1ps

module ov7670_dvp_emulator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10
) (
  input  logic       clk_24m,
  input  logic       rst_24m_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       cam_VSYNC,
  output logic       cam_HREF,
  output logic [7:0] cam_D,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned LINE   = 2 * (H_ACTIVE + H_BLANK);
  localparam int unsigned H_W    = $clog2(LINE);
  localparam int unsigned V_MAX0 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned V_MAX1 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX  = (V_MAX0 > V_MAX1) ? V_MAX0 : V_MAX1;
  localparam int unsigned V_CLOG = $clog2(V_MAX);
  // at least 9 bits so the line tag can carry y[8]
  localparam int unsigned V_W    = (V_CLOG < 9) ? 9 : V_CLOG;
  localparam int unsigned BAR_W  = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  localparam int unsigned BAR_CL = $clog2(BAR_W);
  localparam int unsigned BAR_CW = (BAR_CL < 1) ? 1 : BAR_CL;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t             state_q, state_nxt;
  logic [H_W-1:0]     h_cnt, h_nxt;
  logic [V_W-1:0]     v_cnt, v_nxt;
  logic [1:0]         rst_sync;
  logic               rst_n;
  logic               line_end, last_line, state_end;
  logic               frame_done_c, vsync_entry_c, href_c;
  logic [7:0]         frame_cnt, frame_cnt_nxt, frame_snap;
  logic [1:0]         pat_q;
  logic [2:0]         bar_idx;
  logic [BAR_CW-1:0]  bar_px;
  logic [7:0]         px_x, y_c, d_c;

  function automatic logic [7:0] bar_luma(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_luma = 8'hEB;
      3'd1:    bar_luma = 8'hD2;
      3'd2:    bar_luma = 8'hAA;
      3'd3:    bar_luma = 8'h91;
      3'd4:    bar_luma = 8'h6A;
      3'd5:    bar_luma = 8'h51;
      3'd6:    bar_luma = 8'h29;
      default: bar_luma = 8'h10;
    endcase
  endfunction

  // Reset synchronizer: assertion is immediate, release is aligned to clk_24m.
  always_ff @(posedge clk_24m or negedge rst_24m_n) begin
    if (!rst_24m_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // State register and line/column counters.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      state_q <= state_nxt;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
    end
  end

  // Next-state, counter and byte decode.
  always_comb begin
    state_nxt     = state_q;
    h_nxt         = h_cnt;
    v_nxt         = v_cnt;
    last_line     = 1'b0;
    frame_done_c  = 1'b0;
    line_end      = (h_cnt == H_W'(LINE - 1));

    case (state_q)
      S_VSYNC:  last_line = (v_cnt == V_W'(V_SYNC - 1));
      S_VBACK:  last_line = (v_cnt == V_W'(V_BACK - 1));
      S_ACTIVE: last_line = (v_cnt == V_W'(V_ACTIVE - 1));
      S_VFRONT: last_line = (v_cnt == V_W'(V_FRONT - 1));
      default:  last_line = 1'b0;
    endcase
    state_end = line_end && last_line;

    case (state_q)
      S_IDLE:   if (enable)    state_nxt = S_VSYNC;
      S_VSYNC:  if (state_end) state_nxt = S_VBACK;
      S_VBACK:  if (state_end) state_nxt = S_ACTIVE;
      S_ACTIVE: if (state_end) state_nxt = S_VFRONT;
      S_VFRONT: if (state_end) begin
        frame_done_c = 1'b1;
        state_nxt    = enable ? S_VSYNC : S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase

    if (state_q == S_IDLE) begin
      h_nxt = '0;
      v_nxt = '0;
    end else begin
      h_nxt = line_end ? '0 : h_cnt + H_W'(1);
      if (state_end)     v_nxt = '0;
      else if (line_end) v_nxt = v_cnt + V_W'(1);
    end

    vsync_entry_c = (state_nxt == S_VSYNC) && (state_q != S_VSYNC);
    frame_cnt_nxt = frame_done_c ? frame_cnt + 8'd1 : frame_cnt;

    href_c = (state_q == S_ACTIVE) && (h_cnt < H_W'(2 * H_ACTIVE));
    px_x   = 8'(h_cnt >> 1);
    case (pat_q)
      2'd0:    y_c = bar_luma(bar_idx);
      2'd1:    y_c = px_x;
      2'd2:    y_c = frame_snap;
      default: y_c = (px_x[3] ^ v_cnt[3]) ? 8'hFF : 8'h00;
    endcase
    // even byte slots carry U/V, odd slots carry Y
    d_c = h_cnt[0] ? y_c : 8'h80;
`ifdef DVP_EMU_LINE_TAG_EN
    if (h_cnt == H_W'(1))      d_c = {7'b0, v_cnt[8]};
    else if (h_cnt == H_W'(3)) d_c = v_cnt[7:0];
`endif
  end

  // Bar position tracks pixel x without a divider; advances after each pixel's second byte.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (state_q != S_ACTIVE || line_end) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (href_c && h_cnt[0]) begin
      if (bar_px == BAR_CW'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px  <= bar_px + BAR_CW'(1);
      end
    end
  end

  // Registered outputs, frame counter and per-frame snapshots.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      cam_VSYNC  <= 1'b0;
      cam_HREF   <= 1'b0;
      cam_D      <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'h00;
      frame_snap <= 8'h00;
      pat_q      <= 2'd0;
    end else begin
      cam_VSYNC  <= (state_q == S_VSYNC);
      cam_HREF   <= href_c;
      cam_D      <= href_c ? d_c : 8'h00;
      frame_done <= frame_done_c;
      busy       <= (state_q != S_IDLE);
      frame_cnt  <= frame_cnt_nxt;
      if (vsync_entry_c) begin
        pat_q      <= pattern_sel;
        frame_snap <= frame_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
`timescale 1ns/1ps

module tb_ov7670_dvp_emulator;

  localparam int FRAME_CLKS = 7 * 24;

  logic       clk_24m = 1'b0;
  logic       rst_24m_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       cam_VSYNC, cam_HREF, frame_done, busy;
  logic [7:0] cam_D;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] cap_bytes [4][16];
  int         cap_len [4];
  int         cap_vs_width, cap_vs_cyc, cap_fd_cyc, cap_idle_d_bad, cap_href_pre;
  logic       cap_fd_busy;
  bit         cap_timeout;

  logic [7:0] bar_y [8] = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};

  ov7670_dvp_emulator #(
    .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
  ) dut (
    .clk_24m     (clk_24m),
    .rst_24m_n   (rst_24m_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .cam_VSYNC   (cam_VSYNC),
    .cam_HREF    (cam_HREF),
    .cam_D       (cam_D),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk_24m = ~clk_24m;
  always @(posedge clk_24m) cyc <= cyc + 1;

  task automatic apply_reset();
    enable      = 1'b0;
    pattern_sel = 2'd0;
    rst_24m_n   = 1'b0;
    repeat (3) @(negedge clk_24m);
    rst_24m_n   = 1'b1;
    repeat (3) @(negedge clk_24m);
  endtask

  // Records one frame of outputs (sampled on falling edges); comparisons happen in the tests.
  task automatic capture_frame();
    int n;
    cap_timeout = 0; cap_idle_d_bad = 0; cap_href_pre = 0; cap_vs_width = 0;
    cap_fd_busy = 1'b0;
    for (int l = 0; l < 4; l++) cap_len[l] = 0;
    n = 0;
    while (cam_VSYNC !== 1'b1 && n < 400) begin
      if (cam_HREF === 1'b1) cap_href_pre++;
      @(negedge clk_24m); n++;
    end
    if (cam_VSYNC !== 1'b1) begin cap_timeout = 1; return; end
    cap_vs_cyc = cyc;
    while (cam_VSYNC === 1'b1 && cap_vs_width < 400) begin
      cap_vs_width++; @(negedge clk_24m);
    end
    for (int l = 0; l < 4; l++) begin
      n = 0;
      while (cam_HREF !== 1'b1 && n < 200) begin
        if (cam_D !== 8'h00) cap_idle_d_bad++;
        @(negedge clk_24m); n++;
      end
      if (cam_HREF !== 1'b1) begin cap_timeout = 1; return; end
      while (cam_HREF === 1'b1 && cap_len[l] < 40) begin
        if (cap_len[l] < 16) cap_bytes[l][cap_len[l]] = cam_D;
        cap_len[l]++; @(negedge clk_24m);
      end
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      if (cam_D !== 8'h00) cap_idle_d_bad++;
      @(negedge clk_24m); n++;
    end
    if (frame_done !== 1'b1) begin cap_timeout = 1; return; end
    cap_fd_cyc  = cyc;
    cap_fd_busy = busy;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_24m_n = 1'b0;
    #1;
    n_checks++;
    if ({cam_VSYNC, cam_HREF, busy, frame_done, cam_D} !== 12'h000) begin
      n_fail++; $display("FAIL reset_hold: outputs=%h expected 000", {cam_VSYNC, cam_HREF, busy, frame_done, cam_D});
    end
    @(negedge clk_24m);
    rst_24m_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24m);
      n_checks++;
      if ({cam_VSYNC, cam_HREF, busy, frame_done, cam_D} !== 12'h000) begin
        n_fail++; $display("FAIL idle_outputs cyc %0d: outputs=%h expected 000", i, {cam_VSYNC, cam_HREF, busy, frame_done, cam_D});
      end
    end
  endtask

  task automatic test_ramp();
    logic [7:0] e;
    apply_reset();
    pattern_sel = 2'd1;
    enable = 1'b1;
    capture_frame();
    enable = 1'b0;
    n_checks++;
    if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout: got 1 expected 0"); end
    n_checks++;
    if (cap_vs_width !== 24) begin n_fail++; $display("FAIL ramp_vsync_width: got %0d expected 24", cap_vs_width); end
    n_checks++;
    if (cap_href_pre !== 0) begin n_fail++; $display("FAIL ramp_href_before_vsync: got %0d expected 0", cap_href_pre); end
    for (int l = 0; l < 4; l++) begin
      n_checks++;
      if (cap_len[l] !== 16) begin n_fail++; $display("FAIL ramp_href_len line %0d: got %0d expected 16", l, cap_len[l]); end
      for (int i = 0; i < 16; i++) begin
        e = (i % 2 == 0) ? 8'h80 : 8'(i / 2);
`ifdef DVP_EMU_LINE_TAG_EN
        if (i == 1) e = 8'h00;
        if (i == 3) e = 8'(l);
`endif
        n_checks++;
        if (cap_bytes[l][i] !== e) begin
          n_fail++; $display("FAIL ramp_byte l%0d b%0d: got %h expected %h", l, i, cap_bytes[l][i], e);
        end
      end
    end
    n_checks++;
    if (cap_fd_cyc - cap_vs_cyc !== FRAME_CLKS - 1) begin
      n_fail++; $display("FAIL ramp_frame_done_offset: got %0d expected %0d", cap_fd_cyc - cap_vs_cyc, FRAME_CLKS - 1);
    end
    n_checks++;
    if (cap_idle_d_bad !== 0) begin n_fail++; $display("FAIL ramp_d_when_href_low: got %0d nonzero expected 0", cap_idle_d_bad); end
  endtask

  task automatic test_back_to_back();
    int prev_fd;
    logic [7:0] e;
    apply_reset();
    pattern_sel = 2'd2;
    enable = 1'b1;
    prev_fd = 0;
    for (int f = 0; f < 3; f++) begin
      capture_frame();
      n_checks++;
      if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout frame %0d: got 1 expected 0", f); end
      n_checks++;
      if (cap_vs_width !== 24) begin n_fail++; $display("FAIL b2b_vsync_width frame %0d: got %0d expected 24", f, cap_vs_width); end
      n_checks++;
      if (cap_fd_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_at_done frame %0d: got %b expected 1", f, cap_fd_busy); end
      for (int l = 0; l < 4; l++) begin
        for (int i = 0; i < 16; i++) begin
          e = (i % 2 == 0) ? 8'h80 : 8'(f);
`ifdef DVP_EMU_LINE_TAG_EN
          if (i == 1) e = 8'h00;
          if (i == 3) e = 8'(l);
`endif
          n_checks++;
          if (cap_bytes[l][i] !== e) begin
            n_fail++; $display("FAIL b2b_byte f%0d l%0d b%0d: got %h expected %h", f, l, i, cap_bytes[l][i], e);
          end
        end
      end
      if (f > 0) begin
        n_checks++;
        if (cap_fd_cyc - prev_fd !== FRAME_CLKS) begin
          n_fail++; $display("FAIL b2b_done_period frame %0d: got %0d expected %0d", f, cap_fd_cyc - prev_fd, FRAME_CLKS);
        end
      end
      prev_fd = cap_fd_cyc;
    end
    enable = 1'b0;
  endtask

  task automatic test_pattern_switch();
    logic [7:0] e;
    int n;
    apply_reset();
    pattern_sel = 2'd0;
    enable = 1'b1;
    fork
      capture_frame();
      begin
        n = 0;
        while (cam_HREF !== 1'b1 && n < 500) begin @(negedge clk_24m); n++; end
        pattern_sel = 2'd3;
      end
    join
    n_checks++;
    if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL switch_bars_timeout: got 1 expected 0"); end
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        e = (i % 2 == 0) ? 8'h80 : bar_y[i / 2];
`ifdef DVP_EMU_LINE_TAG_EN
        if (i == 1) e = 8'h00;
        if (i == 3) e = 8'(l);
`endif
        n_checks++;
        if (cap_bytes[l][i] !== e) begin
          n_fail++; $display("FAIL switch_bars_byte l%0d b%0d: got %h expected %h", l, i, cap_bytes[l][i], e);
        end
      end
    end
    capture_frame();
    enable = 1'b0;
    n_checks++;
    if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL switch_checker_timeout: got 1 expected 0"); end
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        // x < 8 and y < 4, so x[3]^y[3] is 0 everywhere: dark checker square
        e = (i % 2 == 0) ? 8'h80 : 8'h00;
`ifdef DVP_EMU_LINE_TAG_EN
        if (i == 3) e = 8'(l);
`endif
        n_checks++;
        if (cap_bytes[l][i] !== e) begin
          n_fail++; $display("FAIL switch_checker_byte l%0d b%0d: got %h expected %h", l, i, cap_bytes[l][i], e);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int n, bad_busy, bad_vs;
    apply_reset();
    pattern_sel = 2'd1;
    enable = 1'b1;
    fork
      capture_frame();
      begin
        n = 0;
        while (cam_VSYNC !== 1'b1 && n < 400) begin @(negedge clk_24m); n++; end
        n = 0;
        while (cam_VSYNC === 1'b1 && n < 400) begin @(negedge clk_24m); n++; end
        enable = 1'b0;
      end
    join
    n_checks++;
    if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL drop_timeout: got 1 expected 0"); end
    for (int l = 0; l < 4; l++) begin
      n_checks++;
      if (cap_len[l] !== 16) begin n_fail++; $display("FAIL drop_href_len line %0d: got %0d expected 16", l, cap_len[l]); end
    end
    n_checks++;
    if (cap_fd_cyc - cap_vs_cyc !== FRAME_CLKS - 1) begin
      n_fail++; $display("FAIL drop_frame_done_offset: got %0d expected %0d", cap_fd_cyc - cap_vs_cyc, FRAME_CLKS - 1);
    end
    n_checks++;
    if (cap_fd_busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy_at_done: got %b expected 1", cap_fd_busy); end
    bad_busy = 0; bad_vs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_24m);
      if (busy !== 1'b0) bad_busy++;
      if (cam_VSYNC !== 1'b0 || cam_HREF !== 1'b0) bad_vs++;
    end
    n_checks++;
    if (bad_busy !== 0) begin n_fail++; $display("FAIL drop_busy_after: got %0d busy clks expected 0", bad_busy); end
    n_checks++;
    if (bad_vs !== 0) begin n_fail++; $display("FAIL drop_sync_after: got %0d active clks expected 0", bad_vs); end
  endtask

  task automatic test_reset_midline();
    int n;
    logic href_seen;
    apply_reset();
    pattern_sel = 2'd1;
    enable = 1'b1;
    n = 0;
    while (cam_HREF !== 1'b1 && n < 500) begin @(negedge clk_24m); n++; end
    repeat (3) @(negedge clk_24m);
    href_seen = cam_HREF;
    n_checks++;
    if (href_seen !== 1'b1) begin n_fail++; $display("FAIL midline_setup_href: got %b expected 1", href_seen); end
    @(posedge clk_24m);
    #3;
    rst_24m_n = 1'b0;
    #1;
    n_checks++;
    if ({cam_VSYNC, cam_HREF, busy, frame_done, cam_D} !== 12'h000) begin
      n_fail++; $display("FAIL midline_reset_outputs: got %h expected 000", {cam_VSYNC, cam_HREF, busy, frame_done, cam_D});
    end
    repeat (3) @(negedge clk_24m);
    rst_24m_n = 1'b1;
    capture_frame();
    enable = 1'b0;
    n_checks++;
    if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL midline_restart_timeout: got 1 expected 0"); end
    n_checks++;
    if (cap_href_pre !== 0) begin n_fail++; $display("FAIL midline_href_before_vsync: got %0d expected 0", cap_href_pre); end
    n_checks++;
    if (cap_vs_width !== 24) begin n_fail++; $display("FAIL midline_vsync_width: got %0d expected 24", cap_vs_width); end
    n_checks++;
    if (cap_len[0] !== 16) begin n_fail++; $display("FAIL midline_first_line_len: got %0d expected 16", cap_len[0]); end
    n_checks++;
    if (cap_bytes[0][15] !== 8'h07) begin n_fail++; $display("FAIL midline_last_byte: got %h expected 07", cap_bytes[0][15]); end
    n_checks++;
    if (cap_fd_cyc - cap_vs_cyc !== FRAME_CLKS - 1) begin
      n_fail++; $display("FAIL midline_frame_done_offset: got %0d expected %0d", cap_fd_cyc - cap_vs_cyc, FRAME_CLKS - 1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_pattern_switch();
    test_enable_drop();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
